// File: rtl/switch_matrix_pkg.sv
// Shared definitions for the MT8816 crosspoint switch-matrix controller:
// host opcodes, FSM state codes, cmd_data field offsets and the X-address
// remap applied when a command is popped from the queue.
package switch_matrix_pkg;

    localparam logic [1:0] OP_NOP       = 2'd0;
    localparam logic [1:0] OP_WRITE     = 2'd1;
    localparam logic [1:0] OP_RESET_ONE = 2'd2;
    localparam logic [1:0] OP_RESET_ALL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_SETUP   = 4'd2,
        S_GAP     = 4'd3,
        S_LOAD    = 4'd4,
        S_STROBE  = 4'd5,
        S_HOLD    = 4'd6,
        S_CHIPRST = 4'd7
    } state_t;

    // cmd_data layout
    localparam int X_LSB    = 0;   // [3:0] X code
    localparam int IDX_LSB  = 4;   // [6:4] chip index
    localparam int Y_LSB    = 7;   // [9:7] Y address
    localparam int DATA_BIT = 11;  // 1 = close switch

    // queued entry is {op, data}
    localparam int CMD_W = 18;

    // The MT8816 AX decode skips codes 6/7 in the middle of the X range,
    // so logical X 6..11 sit two codes higher and logical 12/13 land on 6/7.
    function automatic logic [3:0] remap_ax(input logic [3:0] x);
        logic [3:0] r;
        r = x;
        if (x >= 4'd6 && x <= 4'd11) r = x + 4'd2;
        else if (x == 4'd12)         r = 4'd6;
        else if (x == 4'd13)         r = 4'd7;
        return r;
    endfunction

endpackage

// File: rtl/sw_cmd_fifo.sv
// Show-ahead command FIFO for the switch-matrix controller.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write one {op,data} entry (caller guarantees !full)
//   pop             drop the head entry (caller guarantees !empty)
//   rdata           current head entry, valid whenever !empty
//   full, empty     occupancy flags
module sw_cmd_fifo
    import switch_matrix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    // one extra pointer bit distinguishes full from empty when the
    // address bits match; wrap is just natural binary overflow
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/switch_matrix_ctrl.sv
// Controller for NUM_SW MT8816 crosspoint chips on a shared AX/AY/DATA/STROBE
// bus with per-chip CS and RESET. Host commands are queued, then sequenced
// one at a time with parameterised bus timing. Every reset release runs a
// power-on clear of all chips before commands are accepted.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake (NOPs are swallowed)
//   cmd_op, cmd_data        opcode and {DATA, Y, chip index, X} fields
//   rdy                     idle with nothing queued
//   state                   FSM state code (debug)
//   err                     one-cycle pulse: popped command had a bad chip index
//   RESET_SW, CS_SW         per-chip RESET and chip select
//   AX, AY, STROBE, DATA    shared crosspoint bus
module switch_matrix_ctrl
    import switch_matrix_pkg::*;
#(
    parameter int NUM_SW     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int T_RESET    = 6,
    parameter int T_SETUP    = 2,
    parameter int T_STROBE   = 3,
    parameter int T_HOLD     = 2,
    parameter int T_GAP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_data,
    output logic              rdy,
    output logic [3:0]        state,
    output logic              err,
    output logic [NUM_SW-1:0] RESET_SW,
    output logic [NUM_SW-1:0] CS_SW,
    output logic [3:0]        AX,
    output logic [2:0]        AY,
    output logic              STROBE,
    output logic              DATA
);

    state_t             state_q;
    logic [7:0]         cnt;        // shared phase down-counter (T_* <= 256)

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CMD_W-1:0]   fifo_dout;

    logic [1:0]         head_op;
    logic [2:0]         head_idx;
    logic               head_bad;

    // command captured at pop, driven onto the bus in S_LOAD
    logic [1:0]         sel_op;
    logic [2:0]         sel_idx;
    logic [3:0]         sel_x;
    logic [2:0]         sel_y;
    logic               sel_d;
    logic [NUM_SW-1:0]  sel_mask;

    logic               unused_head_bits;

    assign cmd_ready = (state_q != S_INIT) && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready && (cmd_op != OP_NOP);
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;

    sw_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({cmd_op, cmd_data}),
        .pop   (fifo_pop),
        .rdata (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op  = fifo_dout[17:16];
    assign head_idx = fifo_dout[IDX_LSB +: 3];
    // RESET_ALL addresses every chip, so its index field is don't-care
    assign head_bad = (head_op != OP_RESET_ALL) && (int'(head_idx) >= NUM_SW);
    assign unused_head_bits = ^{fifo_dout[15:12], fifo_dout[10]};

    assign sel_mask = NUM_SW'(1) << sel_idx;
    assign rdy      = (state_q == S_IDLE) && fifo_empty;
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            cnt      <= '0;
            sel_op   <= OP_NOP;
            sel_idx  <= '0;
            sel_x    <= '0;
            sel_y    <= '0;
            sel_d    <= 1'b0;
            err      <= 1'b0;
            RESET_SW <= '0;
            CS_SW    <= '0;
            AX       <= '0;
            AY       <= '0;
            STROBE   <= 1'b0;
            DATA     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_q)
                // RESET_SW still low means the clear has not started yet
                S_INIT: begin
                    if (RESET_SW == '0) begin
                        RESET_SW <= '1;
                        cnt      <= 8'(T_RESET - 1);
                    end else if (cnt == '0) begin
                        RESET_SW <= '0;
                        cnt      <= 8'(T_GAP - 1);
                        state_q  <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_bad) begin
                            err <= 1'b1;
                        end else begin
                            sel_op  <= head_op;
                            sel_idx <= head_idx;
                            sel_x   <= remap_ax(fifo_dout[X_LSB +: 4]);
                            sel_y   <= fifo_dout[Y_LSB +: 3];
                            sel_d   <= fifo_dout[DATA_BIT];
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    AX   <= sel_x;
                    AY   <= sel_y;
                    DATA <= sel_d;
                    if (sel_op == OP_WRITE) begin
                        CS_SW   <= sel_mask;
                        cnt     <= 8'(T_SETUP - 1);
                        state_q <= S_SETUP;
                    end else begin
                        RESET_SW <= (sel_op == OP_RESET_ALL) ? '1 : sel_mask;
                        cnt      <= 8'(T_RESET - 1);
                        state_q  <= S_CHIPRST;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        STROBE  <= 1'b1;
                        cnt     <= 8'(T_STROBE - 1);
                        state_q <= S_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        STROBE  <= 1'b0;
                        cnt     <= 8'(T_HOLD - 1);
                        state_q <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        CS_SW   <= '0;
                        cnt     <= 8'(T_GAP - 1);
                        state_q <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHIPRST: begin
                    if (cnt == '0) begin
                        RESET_SW <= '0;
                        cnt      <= 8'(T_GAP - 1);
                        state_q  <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) state_q <= S_IDLE;
                    else           cnt     <= cnt - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_matrix_ctrl.sv
module tb_switch_matrix_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rdy;
    logic [3:0]  state;
    logic        err;
    logic [1:0]  RESET_SW;
    logic [1:0]  CS_SW;
    logic [3:0]  AX;
    logic [2:0]  AY;
    logic        STROBE;
    logic        DATA;

    int checks = 0;
    int errors = 0;

    // back-to-back vectors: X in, remapped AX expected, Y, DATA
    logic [3:0] b2b_x  [5] = '{4'd6, 4'd11, 4'd12, 4'd0, 4'd15};
    logic [3:0] b2b_ax [5] = '{4'd8, 4'd13, 4'd6,  4'd0, 4'd15};
    logic [2:0] b2b_y  [5] = '{3'd1, 3'd2,  3'd3,  3'd4, 3'd7};
    logic       b2b_d  [5] = '{1'b1, 1'b0,  1'b1,  1'b0, 1'b1};

    always #5 clk = ~clk;

    switch_matrix_ctrl #(
        .NUM_SW(2), .FIFO_DEPTH(4), .T_RESET(6), .T_SETUP(2),
        .T_STROBE(3), .T_HOLD(2), .T_GAP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rdy(rdy), .state(state),
        .err(err), .RESET_SW(RESET_SW), .CS_SW(CS_SW), .AX(AX), .AY(AY),
        .STROBE(STROBE), .DATA(DATA)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] idx, input logic [3:0] x,
                                       input logic [2:0] y, input logic d);
        return {4'b0000, d, 1'b0, y, idx, x};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 16'h0000;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if ({RESET_SW, CS_SW, AX, AY, STROBE, DATA, err, cmd_ready, rdy} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {RESET_SW, CS_SW, AX, AY, STROBE, DATA, err, cmd_ready, rdy});
        end
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL reset_state got %0d exp 1", state);
        end
    endtask

    task automatic test_power_on_clear(input string tag);
        logic [1:0] exp_rst;
        logic       exp_ready;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_rst   = (k <= 6) ? 2'b11 : 2'b00;
            exp_ready = (k >= 7);
            checks++;
            if (RESET_SW !== exp_rst) begin
                errors++;
                $display("FAIL %s_reset_sw cyc %0d got %b exp %b", tag, k, RESET_SW, exp_rst);
            end
            checks++;
            if (cmd_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s_cmd_ready cyc %0d got %b exp %b", tag, k, cmd_ready, exp_ready);
            end
            if (k == 7) begin
                checks++;
                if (state !== 4'd3 || rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_gap got state %0d rdy %b exp state 3 rdy 0", tag, state, rdy);
                end
            end
            if (k == 8) begin
                checks++;
                if (rdy !== 1'b1 || state !== 4'd0) begin
                    errors++;
                    $display("FAIL %s_idle got state %0d rdy %b exp state 0 rdy 1", tag, state, rdy);
                end
            end
        end
    endtask

    task automatic test_write();
        logic [1:0] exp_cs;
        logic       exp_stb;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready got %b exp 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = 16'h0A8D;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_cs  = (k >= 2 && k <= 8) ? 2'b01 : 2'b00;
            exp_stb = (k >= 4 && k <= 6);
            checks++;
            if (CS_SW !== exp_cs) begin
                errors++;
                $display("FAIL write_cs cyc %0d got %b exp %b", k, CS_SW, exp_cs);
            end
            checks++;
            if (STROBE !== exp_stb) begin
                errors++;
                $display("FAIL write_strobe cyc %0d got %b exp %b", k, STROBE, exp_stb);
            end
            if (k == 4) begin
                checks++;
                if (AX !== 4'd7 || AY !== 3'd5 || DATA !== 1'b1) begin
                    errors++;
                    $display("FAIL write_bus got AX %0d AY %0d DATA %b exp AX 7 AY 5 DATA 1",
                             AX, AY, DATA);
                end
            end
            if (k == 9 || k == 10) begin
                checks++;
                if (rdy !== (k == 10)) begin
                    errors++;
                    $display("FAIL write_rdy cyc %0d got %b exp %b", k, rdy, (k == 10));
                end
            end
        end
    endtask

    task automatic test_nop();
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_data  = mk(3'd0, 4'd1, 3'd1, 1'b1);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_ready got %b exp 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (rdy !== 1'b1 || CS_SW !== 2'b00 || state !== 4'd0) begin
                errors++;
                $display("FAIL nop_idle cyc %0d got rdy %b cs %b state %0d exp rdy 1 cs 00 state 0",
                         k, rdy, CS_SW, state);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   seen;
        logic acc;
        logic prev_cs;
        n       = 0;
        seen    = 0;
        prev_cs = 1'b0;
        fork
            begin
                cmd_op = 2'd1;
                for (int c = 0; c < 40 && n < 5; c++) begin
                    cmd_valid = 1'b1;
                    cmd_data  = mk(3'd1, b2b_x[n], b2b_y[n], b2b_d[n]);
                    acc       = cmd_ready;
                    step();
                    if (acc) begin
                        n++;
                        if (n == 5) begin
                            checks++;
                            if (cmd_ready !== 1'b0) begin
                                errors++;
                                $display("FAIL b2b_full_ready got %b exp 0", cmd_ready);
                            end
                        end
                    end
                end
                cmd_valid = 1'b0;
                checks++;
                if (n != 5) begin
                    errors++;
                    $display("FAIL b2b_accepts got %0d exp 5", n);
                end
            end
            begin
                for (int c = 0; c < 75; c++) begin
                    step();
                    if (CS_SW != 2'b00 && !prev_cs && seen < 5) begin
                        checks++;
                        if (CS_SW !== 2'b10 || AX !== b2b_ax[seen] || AY !== b2b_y[seen] ||
                            DATA !== b2b_d[seen]) begin
                            errors++;
                            $display("FAIL b2b_cmd%0d got cs %b AX %0d AY %0d D %b exp cs 10 AX %0d AY %0d D %b",
                                     seen, CS_SW, AX, AY, DATA, b2b_ax[seen], b2b_y[seen], b2b_d[seen]);
                        end
                        seen++;
                    end
                    prev_cs = (CS_SW != 2'b00);
                end
                checks++;
                if (seen != 5 || rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_executed got %0d rdy %b exp 5 rdy 1", seen, rdy);
                end
            end
        join
    endtask

    task automatic test_bad_index();
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = mk(3'd3, 4'd1, 3'd1, 1'b1);
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (err !== (k == 1)) begin
                errors++;
                $display("FAIL bad_err cyc %0d got %b exp %b", k, err, (k == 1));
            end
            checks++;
            if (CS_SW !== 2'b00 || STROBE !== 1'b0) begin
                errors++;
                $display("FAIL bad_bus cyc %0d got cs %b strobe %b exp 00 0", k, CS_SW, STROBE);
            end
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL bad_rdy got %b exp 1", rdy);
        end
    endtask

    task automatic test_chip_reset();
        logic [1:0] exp_rst;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_data  = mk(3'd1, 4'd0, 3'd0, 1'b0);
        step();
        cmd_op    = 2'd3;
        cmd_data  = mk(3'd7, 4'd0, 3'd0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            step();
            cmd_valid = 1'b0;
            exp_rst = (k >= 2 && k <= 7)  ? 2'b10 :
                      (k >= 11 && k <= 16) ? 2'b11 : 2'b00;
            checks++;
            if (RESET_SW !== exp_rst) begin
                errors++;
                $display("FAIL chiprst_sw cyc %0d got %b exp %b", k, RESET_SW, exp_rst);
            end
            checks++;
            if (CS_SW !== 2'b00 || err !== 1'b0) begin
                errors++;
                $display("FAIL chiprst_cs_err cyc %0d got cs %b err %b exp 00 0", k, CS_SW, err);
            end
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL chiprst_rdy got %b exp 1", rdy);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int bad;
        bit hit;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = mk(3'd0, 4'd2, 3'd2, 1'b1);
        step();
        cmd_data  = mk(3'd1, 4'd3, 3'd3, 1'b0);
        step();
        cmd_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (STROBE === 1'b1) hit = 1'b1;
            else step();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrst_strobe_seen got 0 exp 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({RESET_SW, CS_SW, STROBE, err, cmd_ready, rdy} !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs got %h exp 0", {RESET_SW, CS_SW, STROBE, err, cmd_ready, rdy});
        end
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL midrst_state got %0d exp 1", state);
        end
        step();
        step();
        test_power_on_clear("rerun");
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (CS_SW !== 2'b00 || STROBE !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_flushed got %0d active cycles rdy %b exp 0 rdy 1", bad, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_power_on_clear("por");
        test_write();
        test_nop();
        test_back_to_back();
        test_bad_index();
        test_chip_reset();
        test_reset_mid_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
